rv32_decode_stage: RTL and testbench
====================================

# rv32_decode_stage

Registered, flow-controlled RV32IM decode stage between the fetch queue and the reservation-station dispatch logic. It decodes one instruction per accepted transfer into the same control fields the combinational decoder produces: ALU op, RS entry, register selects, immediate and multiply/divide request controls. It extends that decoder with a valid/ready handshake, a two-entry skid buffer, pipeline flush, a build-time M-extension switch and saturating event counters.

## Interface
- ENABLE_M, default 1: when 1, OP with funct7 = RV32_FUNCT7_MUL_DIV decodes as MUL/DIV; when 0, it is flagged illegal.
- CNT_WIDTH, default 16: width of the statistics counters.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- in_valid  in  1  fetch presents in_inst/in_pc.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- flush  in  1  discard all held entries.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  dispatch consumes.
- out_pc, out_inst  out  32 each  passthrough of the accepted pc/inst.
- rs1, rs2, rd  out  REG_SEL each  register fields inst[19:15], inst[24:20], inst[11:7].
- uses_rs1, uses_rs2, wr_reg, illegal_instruction  out  1 each  decode flags.
- alu_op  out  ALU_OP_WIDTH  ALU operation.
- rs_ent  out  RS_ENT_SEL  target reservation station.
- imm_type  out  IMM_TYPE_WIDTH  immediate format.
- imm  out  32  sign-extended immediate.
- md_req_in_1_signed, md_req_in_2_signed  out  1 each  multiply/divide operand signedness.
- md_req_out_sel  out  MD_OUT_SEL_WIDTH  multiply/divide result selector.
- illegal_count, md_count  out  CNT_WIDTH each  saturating counters.

## Operation
- Occupancy state machine: EMPTY, ONE (output register valid), TWO (output register plus skid register valid).
- in_ready = (state != TWO).
- A transfer is accept = in_valid & in_ready. A drain is out_valid & out_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & !drain → TWO.
  - ONE + drain & !accept → EMPTY.
  - ONE + accept & drain → ONE; the new entry replaces the output register.
  - TWO + drain → ONE; the skid entry moves to the output register. No accept is possible in TWO.
- flush forces EMPTY on the next edge and overrides any simultaneous accept or drain. An instruction accepted in the flush cycle is discarded and not counted.
- Decode is combinational on in_inst and captured at accept.
- Decode rules:
  - LOAD and STORE → RS_ENT_LDST.
  - BRANCH → RS_ENT_BRANCH; funct3 BEQ/BNE/BLT/BLTU/BGE/BGEU → ALU_OP_SEQ/SNE/SLT/SLTU/SGE/SGEU.
  - JAL → RS_ENT_JAL; JALR → RS_ENT_JALR.
  - OP and OP_IMM → RS_ENT_ALU with funct3 mapping to ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - SUB only when opcode = OP and funct7[5] = 1.
  - SRA when funct7[5] = 1, otherwise SRL.
  - LUI and AUIPC → ALU_OP_ADD, RS_ENT_ALU.
- M extension (ENABLE_M = 1):
  - funct3 MUL/MULH/MULHSU/MULHU → RS_ENT_MUL; DIV/DIVU/REM/REMU → RS_ENT_DIV.
  - md_req_out_sel: MUL → MD_OUT_LO; MULH/MULHSU/MULHU → MD_OUT_HI; DIV/DIVU → MD_OUT_LO; REM/REMU → MD_OUT_REM.
  - in_1 signed for MULH, MULHSU, DIV, REM; in_2 signed for MULH, DIV, REM. All other cases 0.
- wr_reg = 1 for LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR, but forced 0 when rd = 0.
- uses_rs1 = 0 for LUI, AUIPC, JAL. uses_rs2 = 1 only for OP, STORE, BRANCH.
- Immediates are I/S/B/U/J format, sign-extended from inst[31]; U-type is inst[31:12]<<12.
- Unknown opcode, or MUL/DIV encoding with ENABLE_M = 0, sets illegal_instruction = 1 with wr_reg 0, uses_rs* 0, alu_op ADD, rs_ent ALU.
- Counters increment on a non-flushed accept: illegal_count for illegal instructions, md_count for MUL/DIV. Both saturate at all-ones and never wrap.

## Timing
- Latency: an accept at edge N makes out_valid = 1 after edge N.
- Sustained throughput is 1 per cycle with out_ready held at 1.
- in_ready is registered state only; there is no combinational path from out_ready to in_ready.
- Reset (reset = 0) takes effect immediately, independent of clk:
  - state EMPTY, out_valid 0, all payload outputs 0, counters 0.
  - in_ready reads 1, but no transfer occurs while reset = 0.
- Reset asserted mid-operation drops both entries. The first accept can happen at the first edge after reset returns to 1.
- While out_valid = 1 and out_ready = 0, all out_* fields hold stable.

## Test plan
- Reset with out_ready = 1, then stream ADD x3,x1,x2 (0x002081B3) → one cycle later out_valid = 1, alu_op ALU_OP_ADD, rs_ent RS_ENT_ALU, rd 3, wr_reg 1, uses_rs2 1.
- Hold out_ready = 0 and offer 3 instructions back-to-back → first 2 accepted, in_ready = 0 on cycle 3. Raise out_ready → drained in order, no loss or duplication.
- MULHSU 0x0220A1B3 with ENABLE_M = 1 → rs_ent RS_ENT_MUL, md_req_out_sel MD_OUT_HI, in_1_signed 1, in_2_signed 0, md_count = 1. Same word with ENABLE_M = 0 → illegal_instruction 1, illegal_count = 1.
- Assert flush in state TWO with a simultaneous in_valid → state EMPTY next cycle, out_valid 0, counters unchanged.
- With CNT_WIDTH = 4, feed 20 illegal words (0xFFFFFFFF) → illegal_count stops at 15.
- Drop reset to 0 mid-stream in state ONE → out_valid falls immediately, without waiting for a clock edge, and counters read 0.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// RV32IM decode stage: combinational decode captured into a two-entry
// valid/ready skid buffer, with flush and saturating event counters.
module rv32_decode_stage #(
  parameter bit ENABLE_M  = 1'b1,
  parameter int CNT_WIDTH = 16,
  localparam int REG_SEL          = 5,
  localparam int ALU_OP_WIDTH     = 4,
  localparam int RS_ENT_SEL       = 3,
  localparam int IMM_TYPE_WIDTH   = 3,
  localparam int MD_OUT_SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_inst,
  input  logic [31:0]                 in_pc,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_inst,
  output logic [REG_SEL-1:0]          rs1,
  output logic [REG_SEL-1:0]          rs2,
  output logic [REG_SEL-1:0]          rd,
  output logic                        uses_rs1,
  output logic                        uses_rs2,
  output logic                        wr_reg,
  output logic                        illegal_instruction,
  output logic [ALU_OP_WIDTH-1:0]     alu_op,
  output logic [RS_ENT_SEL-1:0]       rs_ent,
  output logic [IMM_TYPE_WIDTH-1:0]   imm_type,
  output logic [31:0]                 imm,
  output logic                        md_req_in_1_signed,
  output logic                        md_req_in_2_signed,
  output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic [CNT_WIDTH-1:0]        illegal_count,
  output logic [CNT_WIDTH-1:0]        md_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV32_FUNCT7_MUL_DIV = 7'b0000001;

  localparam logic [3:0] ALU_OP_ADD = 4'd0,  ALU_OP_SUB  = 4'd1,  ALU_OP_SLL = 4'd2;
  localparam logic [3:0] ALU_OP_SLT = 4'd3,  ALU_OP_SLTU = 4'd4,  ALU_OP_XOR = 4'd5;
  localparam logic [3:0] ALU_OP_SRL = 4'd6,  ALU_OP_SRA  = 4'd7,  ALU_OP_OR  = 4'd8;
  localparam logic [3:0] ALU_OP_AND = 4'd9,  ALU_OP_SEQ  = 4'd10, ALU_OP_SNE = 4'd11;
  localparam logic [3:0] ALU_OP_SGE = 4'd12, ALU_OP_SGEU = 4'd13;

  localparam logic [2:0] RS_ENT_ALU  = 3'd0, RS_ENT_BRANCH = 3'd1, RS_ENT_JAL = 3'd2;
  localparam logic [2:0] RS_ENT_JALR = 3'd3, RS_ENT_LDST   = 3'd4, RS_ENT_MUL = 3'd5;
  localparam logic [2:0] RS_ENT_DIV  = 3'd6;

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

  localparam logic [1:0] MD_OUT_LO = 2'd0, MD_OUT_HI = 2'd1, MD_OUT_REM = 2'd2;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        wr_reg;
    logic        illegal;
    logic [3:0]  alu_op;
    logic [2:0]  rs_ent;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic        md_in_1_signed;
    logic        md_in_2_signed;
    logic [1:0]  md_out_sel;
  } entry_t;

  state_t state_reg, state_next;
  entry_t out_reg, skid_reg, dec;
  logic [CNT_WIDTH-1:0] illegal_cnt_reg, md_cnt_reg;
  logic accept, drain, out_load, skid_load, skid_move;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Shared OP/OP_IMM mapping; SUB exists only for register-register forms.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                 input logic allow_sub);
    logic [3:0] op;
    op = ALU_OP_ADD;
    case (f3)
      3'b000: op = (alt && allow_sub) ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001: op = ALU_OP_SLL;
      3'b010: op = ALU_OP_SLT;
      3'b011: op = ALU_OP_SLTU;
      3'b100: op = ALU_OP_XOR;
      3'b101: op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110: op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.inst     = in_inst;
    dec.rs1      = in_inst[19:15];
    dec.rs2      = in_inst[24:20];
    dec.rd       = in_inst[11:7];
    dec.alu_op   = ALU_OP_ADD;
    dec.rs_ent   = RS_ENT_ALU;
    dec.imm_type = IMM_NONE;
    unique case (opcode)
      OPC_LOAD: begin
        dec.rs_ent = RS_ENT_LDST; dec.uses_rs1 = 1'b1; dec.wr_reg = 1'b1; dec.imm_type = IMM_I;
      end
      OPC_STORE: begin
        dec.rs_ent = RS_ENT_LDST; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        dec.rs_ent = RS_ENT_BRANCH; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.imm_type = IMM_B;
        case (funct3)
          3'b000:  dec.alu_op = ALU_OP_SEQ;
          3'b001:  dec.alu_op = ALU_OP_SNE;
          3'b100:  dec.alu_op = ALU_OP_SLT;
          3'b101:  dec.alu_op = ALU_OP_SGE;
          3'b110:  dec.alu_op = ALU_OP_SLTU;
          3'b111:  dec.alu_op = ALU_OP_SGEU;
          default: dec.alu_op = ALU_OP_ADD;
        endcase
      end
      OPC_JAL: begin
        dec.rs_ent = RS_ENT_JAL; dec.wr_reg = 1'b1; dec.imm_type = IMM_J;
      end
      OPC_JALR: begin
        dec.rs_ent = RS_ENT_JALR; dec.uses_rs1 = 1'b1; dec.wr_reg = 1'b1; dec.imm_type = IMM_I;
      end
      OPC_OP: begin
        if (in_inst[31:25] == RV32_FUNCT7_MUL_DIV) begin
          if (ENABLE_M) begin
            dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.wr_reg = 1'b1;
            dec.rs_ent = funct3[2] ? RS_ENT_DIV : RS_ENT_MUL;
            case (funct3)
              3'b000:  dec.md_out_sel = MD_OUT_LO;
              3'b001:  begin dec.md_out_sel = MD_OUT_HI; dec.md_in_1_signed = 1'b1; dec.md_in_2_signed = 1'b1; end
              3'b010:  begin dec.md_out_sel = MD_OUT_HI; dec.md_in_1_signed = 1'b1; end
              3'b011:  dec.md_out_sel = MD_OUT_HI;
              3'b100:  begin dec.md_out_sel = MD_OUT_LO; dec.md_in_1_signed = 1'b1; dec.md_in_2_signed = 1'b1; end
              3'b101:  dec.md_out_sel = MD_OUT_LO;
              3'b110:  begin dec.md_out_sel = MD_OUT_REM; dec.md_in_1_signed = 1'b1; dec.md_in_2_signed = 1'b1; end
              default: dec.md_out_sel = MD_OUT_REM;
            endcase
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.wr_reg = 1'b1;
          dec.alu_op = alu_from_funct3(funct3, in_inst[30], 1'b1);
        end
      end
      OPC_OP_IMM: begin
        dec.uses_rs1 = 1'b1; dec.wr_reg = 1'b1; dec.imm_type = IMM_I;
        dec.alu_op = alu_from_funct3(funct3, in_inst[30], 1'b0);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.wr_reg = 1'b1; dec.imm_type = IMM_U;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.wr_reg = 1'b0;
    case (dec.imm_type)
      IMM_I:   dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S:   dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B:   dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      IMM_U:   dec.imm = {in_inst[31:12], 12'd0};
      IMM_J:   dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: dec.imm = 32'd0;
    endcase
  end

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    out_load   = 1'b0;
    skid_load  = 1'b0;
    skid_move  = 1'b0;
    case (state_reg)
      EMPTY: if (accept) begin state_next = ONE; out_load = 1'b1; end
      ONE: begin
        if (accept && !drain) begin state_next = TWO; skid_load = 1'b1; end
        else if (accept && drain) out_load = 1'b1;
        else if (drain) state_next = EMPTY;
      end
      TWO: if (drain) begin state_next = ONE; skid_move = 1'b1; end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
      out_load   = 1'b0;
      skid_load  = 1'b0;
      skid_move  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (skid_move)     out_reg <= skid_reg;
      else if (out_load) out_reg <= dec;
      if (skid_load)     skid_reg <= dec;
    end
  end

  // Counters only see instructions that actually enter the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_cnt_reg <= '0;
      md_cnt_reg      <= '0;
    end else if (accept && !flush) begin
      if (dec.illegal && illegal_cnt_reg != '1)
        illegal_cnt_reg <= illegal_cnt_reg + CNT_WIDTH'(1);
      if ((dec.rs_ent == RS_ENT_MUL || dec.rs_ent == RS_ENT_DIV) && md_cnt_reg != '1)
        md_cnt_reg <= md_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign out_pc              = out_reg.pc;
  assign out_inst            = out_reg.inst;
  assign rs1                 = out_reg.rs1;
  assign rs2                 = out_reg.rs2;
  assign rd                  = out_reg.rd;
  assign uses_rs1            = out_reg.uses_rs1;
  assign uses_rs2            = out_reg.uses_rs2;
  assign wr_reg              = out_reg.wr_reg;
  assign illegal_instruction = out_reg.illegal;
  assign alu_op              = out_reg.alu_op;
  assign rs_ent              = out_reg.rs_ent;
  assign imm_type            = out_reg.imm_type;
  assign imm                 = out_reg.imm;
  assign md_req_in_1_signed  = out_reg.md_in_1_signed;
  assign md_req_in_2_signed  = out_reg.md_in_2_signed;
  assign md_req_out_sel      = out_reg.md_out_sel;
  assign illegal_count       = illegal_cnt_reg;
  assign md_count            = md_cnt_reg;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: an M-enabled instance and an M-disabled,
// 4-bit-counter instance share stimulus and are checked against a queue model.
module tb_rv32_decode_stage;

  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4, A_XOR = 5, A_SRL = 6;
  localparam logic [3:0] A_SRA = 7, A_OR = 8, A_AND = 9, A_SEQ = 10, A_SNE = 11, A_SGE = 12, A_SGEU = 13;
  localparam logic [2:0] E_ALU = 0, E_BR = 1, E_JAL = 2, E_JALR = 3, E_LDST = 4, E_MUL = 5, E_DIV = 6;
  localparam logic [2:0] T_NONE = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5;
  localparam logic [1:0] M_LO = 0, M_HI = 1, M_REM = 2;
  localparam logic [6:0] O_LOAD = 7'h03, O_STORE = 7'h23, O_BRANCH = 7'h63, O_JAL = 7'h6F, O_JALR = 7'h67;
  localparam logic [6:0] O_OP = 7'h33, O_OPIMM = 7'h13, O_LUI = 7'h37, O_AUIPC = 7'h17;

  localparam logic [3:0] ALU_OF_F3 [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam logic [3:0] BR_OF_F3  [8] = '{A_SEQ, A_SNE, A_ADD, A_ADD, A_SLT, A_SGE, A_SLTU, A_SGEU};
  localparam logic [1:0] MSEL_OF_F3[8] = '{M_LO, M_HI, M_HI, M_HI, M_LO, M_LO, M_REM, M_REM};
  localparam logic [6:0] OPC_LIST  [9] = '{O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_OP, O_OPIMM, O_LUI, O_AUIPC};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wr, ill;
    logic [3:0]  alu;
    logic [2:0]  ent;
    logic [2:0]  it;
    logic [31:0] imm;
    logic        s1, s2;
    logic [1:0]  sel;
  } dec_t;

  logic clk, reset, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic a_in_ready, a_out_valid, a_u1, a_u2, a_wr, a_ill, a_s1, a_s2;
  logic [31:0] a_out_pc, a_out_inst, a_imm;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [3:0] a_alu;
  logic [2:0] a_ent, a_it;
  logic [1:0] a_sel;
  logic [15:0] a_ill_cnt, a_md_cnt;

  logic b_in_ready, b_out_valid, b_u1, b_u2, b_wr, b_ill, b_s1, b_s2;
  logic [31:0] b_out_pc, b_out_inst, b_imm;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [3:0] b_alu;
  logic [2:0] b_ent, b_it;
  logic [1:0] b_sel;
  logic [3:0] b_ill_cnt, b_md_cnt;

  dec_t obs_a, obs_b;
  assign obs_a = {a_out_pc, a_out_inst, a_rs1, a_rs2, a_rd, a_u1, a_u2, a_wr, a_ill,
                  a_alu, a_ent, a_it, a_imm, a_s1, a_s2, a_sel};
  assign obs_b = {b_out_pc, b_out_inst, b_rs1, b_rs2, b_rd, b_u1, b_u2, b_wr, b_ill,
                  b_alu, b_ent, b_it, b_imm, b_s1, b_s2, b_sel};

  rv32_decode_stage #(.ENABLE_M(1'b1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_inst(a_out_inst), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .uses_rs1(a_u1), .uses_rs2(a_u2), .wr_reg(a_wr), .illegal_instruction(a_ill),
    .alu_op(a_alu), .rs_ent(a_ent), .imm_type(a_it), .imm(a_imm),
    .md_req_in_1_signed(a_s1), .md_req_in_2_signed(a_s2), .md_req_out_sel(a_sel),
    .illegal_count(a_ill_cnt), .md_count(a_md_cnt));

  rv32_decode_stage #(.ENABLE_M(1'b0), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .uses_rs1(b_u1), .uses_rs2(b_u2), .wr_reg(b_wr), .illegal_instruction(b_ill),
    .alu_op(b_alu), .rs_ent(b_ent), .imm_type(b_it), .imm(b_imm),
    .md_req_in_1_signed(b_s1), .md_req_in_2_signed(b_s2), .md_req_out_sel(b_sel),
    .illegal_count(b_ill_cnt), .md_count(b_md_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] q[$];
  int ill_a, md_a, ill_b, md_b;
  int n_checks = 0;
  int n_err = 0;

  // Reference decode written directly from the instruction-set rules.
  function automatic dec_t ref_dec(input logic [31:0] pc, input logic [31:0] w, input bit en_m);
    dec_t d;
    logic [6:0] opc;
    logic [2:0] f3;
    bit mext;
    opc = w[6:0];
    f3 = w[14:12];
    d = '0;
    d.pc = pc; d.inst = w; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    d.alu = A_ADD; d.ent = E_ALU; d.it = T_NONE;
    mext = (opc == O_OP) && (w[31:25] == 7'b0000001);
    if (!(opc inside {O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_OP, O_OPIMM, O_LUI, O_AUIPC})
        || (mext && !en_m)) begin
      d.ill = 1'b1;
      return d;
    end
    d.u1 = !(opc inside {O_LUI, O_AUIPC, O_JAL});
    d.u2 = opc inside {O_OP, O_STORE, O_BRANCH};
    d.wr = (opc != O_STORE) && (opc != O_BRANCH) && (d.rd != 0);
    if (opc inside {O_LOAD, O_JALR, O_OPIMM}) begin d.it = T_I; d.imm = int'($signed(w[31:20])); end
    if (opc == O_STORE)  begin d.it = T_S; d.imm = int'($signed({w[31:25], w[11:7]})); end
    if (opc == O_BRANCH) begin d.it = T_B; d.imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
    if (opc inside {O_LUI, O_AUIPC}) begin d.it = T_U; d.imm = w & 32'hFFFFF000; end
    if (opc == O_JAL)    begin d.it = T_J; d.imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
    if (opc inside {O_LOAD, O_STORE}) d.ent = E_LDST;
    else if (opc == O_BRANCH) begin d.ent = E_BR; d.alu = BR_OF_F3[f3]; end
    else if (opc == O_JAL) d.ent = E_JAL;
    else if (opc == O_JALR) d.ent = E_JALR;
    else if (mext) begin
      d.ent = (f3 >= 4) ? E_DIV : E_MUL;
      d.sel = MSEL_OF_F3[f3];
      d.s1 = f3 inside {3'd1, 3'd2, 3'd4, 3'd6};
      d.s2 = f3 inside {3'd1, 3'd4, 3'd6};
    end else if (opc inside {O_OP, O_OPIMM}) begin
      d.alu = ALU_OF_F3[f3];
      if (f3 == 3'd0 && opc == O_OP && w[30]) d.alu = A_SUB;
      if (f3 == 3'd5 && w[30]) d.alu = A_SRA;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_in_ready", a_in_ready, q.size() < 2);
    chk("b_in_ready", b_in_ready, q.size() < 2);
    chk("a_out_valid", a_out_valid, q.size() != 0);
    chk("b_out_valid", b_out_valid, q.size() != 0);
    chk("a_illegal_count", a_ill_cnt, ill_a);
    chk("a_md_count", a_md_cnt, md_a);
    chk("b_illegal_count", b_ill_cnt, ill_b);
    chk("b_md_count", b_md_cnt, md_b);
    if (q.size() != 0) begin
      chk("a_payload", obs_a, ref_dec(q[0][63:32], q[0][31:0], 1'b1));
      chk("b_payload", obs_b, ref_dec(q[0][63:32], q[0][31:0], 1'b0));
    end
  endtask

  task automatic count_accept(input logic [31:0] w);
    dec_t da, db;
    da = ref_dec(32'd0, w, 1'b1);
    db = ref_dec(32'd0, w, 1'b0);
    if (da.ill && ill_a != 65535) ill_a++;
    if (!da.ill && da.ent inside {E_MUL, E_DIV} && md_a != 65535) md_a++;
    if (db.ill && ill_b != 15) ill_b++;
    if (!db.ill && db.ent inside {E_MUL, E_DIV} && md_b != 15) md_b++;
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit acc, drn;
    in_valid = v; in_inst = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    check_all();
    acc = v && (q.size() < 2);
    drn = (q.size() != 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin q.push_back({pc, w}); count_accept(w); end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = OPC_LIST[k];
    if (w[6:0] == O_OP) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h10; out_ready = 1'b1; flush = 1'b0;
    ill_a = 0; md_a = 0; ill_b = 0; md_b = 0;
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_payload_a", obs_a, 0);
    chk("rst_payload_b", obs_b, 0);
    chk("rst_counts", {a_ill_cnt, a_md_cnt, b_ill_cnt, b_md_cnt}, 0);
    repeat (2) @(negedge clk);
    chk("rst_no_transfer", {a_out_valid, b_out_valid}, 0);
    in_valid = 1'b0;
    reset = 1'b1;

    // ADD x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    chk("add_valid", a_out_valid, 1);
    chk("add_fields", {a_alu, a_ent, a_rd, a_wr, a_u2}, {A_ADD, E_ALU, 5'd3, 1'b1, 1'b1});
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: three offered, two held, then drained in order.
    step(1'b1, 32'h00500293, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h40B50533, 32'h108, 1'b0, 1'b0);
    chk("bp_full_in_ready", a_in_ready, 0);
    step(1'b1, 32'h00812303, 32'h10C, 1'b0, 1'b0);
    step(1'b1, 32'h00812303, 32'h10C, 1'b1, 1'b0);
    step(1'b1, 32'h00812303, 32'h10C, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // MULHSU x3,x1,x2
    step(1'b1, 32'h0220A1B3, 32'h200, 1'b1, 1'b0);
    chk("mulhsu_fields", {a_ent, a_sel, a_s1, a_s2}, {E_MUL, M_HI, 1'b1, 1'b0});
    chk("mulhsu_md_count", a_md_cnt, 1);
    chk("mulhsu_noM_illegal", {b_ill, b_ill_cnt}, {1'b1, 4'd1});
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush in TWO with in_valid, then flush in ONE with an accept.
    step(1'b1, 32'h00500293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h40B50533, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 32'h308, 1'b1, 1'b1);
    chk("flush_two_empty", {a_out_valid, a_in_ready}, {1'b0, 1'b1});
    chk("flush_two_counts", {a_ill_cnt, b_ill_cnt}, {16'd0, 4'd1});
    step(1'b1, 32'h00500293, 32'h30C, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 32'h310, 1'b0, 1'b1);
    chk("flush_one_counts", {a_out_valid, a_ill_cnt, b_ill_cnt}, {1'b0, 16'd0, 4'd1});

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) step(1'b1, 32'hFFFFFFFF, 32'h400 + 4 * i, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sat_b_illegal", b_ill_cnt, 15);
    chk("sat_a_illegal", a_ill_cnt, 20);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);

    // Asynchronous reset while holding one entry.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0220A1B3, 32'h500, 1'b0, 1'b0);
    chk("pre_rst_valid", a_out_valid, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {a_out_valid, b_out_valid, a_in_ready}, {1'b0, 1'b0, 1'b1});
    chk("async_rst_counts", {a_ill_cnt, a_md_cnt, b_ill_cnt, b_md_cnt}, 0);
    chk("async_rst_payload", obs_a, 0);
    q.delete();
    ill_a = 0; md_a = 0; ill_b = 0; md_b = 0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h002081B3, 32'h600, 1'b1, 1'b0);
    chk("post_rst_accept", a_out_valid, 1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
